qspi_target_regs: RTL and testbench

QSPI_TARGET_REGS -- requirements
Module: qspi_target_regs

---
 rtl/qspi_target_regs.sv | 222 ++++++++++++++++++++++
 tb/tb_qspi_target_regs.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_target_regs.sv
// qspi_target_regs: quad-SPI (mode 0) target bridging nibble-wide transfers onto a byte register bus.
// Commands: 0x02 = write (addr, data...), 0x0B = read (addr, 2 dummy cycles, data...).
module qspi_target_regs (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       qspi_csb,
    input  logic       qspi_sck,
    input  logic [3:0] qspi_io_in,
    output logic [3:0] qspi_io_out,
    output logic [3:0] qspi_io_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata
);

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_READ  = 8'h0B;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE
    } state_e;

    state_e              state_q, state_d;
    logic                csb_s1_q, csb_s2_q;
    logic                sck_s1_q, sck_s2_q, sck_prev_q;
    logic [NIB_W-1:0]    io_s1_q, io_s2_q;
    logic [1:0]          vld_q, vld_d;
    logic                armed_q, armed_d;
    logic                nib_q, nib_d;
    logic                is_rd_q, is_rd_d;
    logic                rd_cap_q, rd_cap_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic [BYTE_W-1:0]   addr_q, addr_d;
    logic [NIB_W-1:0]    io_out_q, io_out_d;
    logic [NIB_W-1:0]    io_oe_q, io_oe_d;
    logic [BYTE_W-1:0]   reg_addr_q, reg_addr_d;
    logic [BYTE_W-1:0]   reg_wdata_q, reg_wdata_d;
    logic                reg_we_q, reg_we_d;
    logic                reg_re_q, reg_re_d;

    logic                sck_rise, sck_fall;
    logic [BYTE_W-1:0]   byte_in;

    assign sck_rise = sck_s2_q & ~sck_prev_q;
    assign sck_fall = ~sck_s2_q & sck_prev_q;
    assign byte_in  = {shift_q[NIB_W-1:0], io_s2_q};

    assign qspi_io_out = io_out_q;
    assign qspi_io_oe  = io_oe_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wdata   = reg_wdata_q;
    assign reg_we      = reg_we_q;
    assign reg_re      = reg_re_q;

    // State register, synchronizers and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            csb_s1_q    <= 1'b1;
            csb_s2_q    <= 1'b1;
            sck_s1_q    <= 1'b0;
            sck_s2_q    <= 1'b0;
            sck_prev_q  <= 1'b0;
            io_s1_q     <= '0;
            io_s2_q     <= '0;
            vld_q       <= '0;
            armed_q     <= 1'b0;
            nib_q       <= 1'b0;
            is_rd_q     <= 1'b0;
            rd_cap_q    <= 1'b0;
            shift_q     <= '0;
            addr_q      <= '0;
            io_out_q    <= '0;
            io_oe_q     <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            csb_s1_q    <= qspi_csb;
            csb_s2_q    <= csb_s1_q;
            sck_s1_q    <= qspi_sck;
            sck_s2_q    <= sck_s1_q;
            sck_prev_q  <= sck_s2_q;
            io_s1_q     <= qspi_io_in;
            io_s2_q     <= io_s1_q;
            vld_q       <= vld_d;
            armed_q     <= armed_d;
            nib_q       <= nib_d;
            is_rd_q     <= is_rd_d;
            rd_cap_q    <= rd_cap_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            io_out_q    <= io_out_d;
            io_oe_q     <= io_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
        end
    end

    // Next-state and output logic; CSB high overrides any coincident SCK edge
    always_comb begin
        state_d     = state_q;
        vld_d       = {vld_q[0], 1'b1};
        armed_d     = armed_q;
        nib_d       = nib_q;
        is_rd_d     = is_rd_q;
        rd_cap_d    = reg_re_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        io_out_d    = io_out_q;
        io_oe_d     = io_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;

        // Only a CSB level that has travelled the whole synchronizer may arm a new transaction
        if (vld_q[1] && csb_s2_q) begin
            armed_d = 1'b1;
        end

        // Read data arrives one clk after the strobe
        if (rd_cap_q) begin
            shift_d = reg_rdata;
        end

        if (state_q != IDLE && csb_s2_q) begin
            state_d = IDLE;
            nib_d   = 1'b0;
            io_oe_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (armed_q && !csb_s2_q) begin
                        state_d = CMD;
                        armed_d = 1'b0;
                        nib_d   = 1'b0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        nib_d   = ~nib_q;
                        shift_d = byte_in;
                        if (nib_q) begin
                            if (byte_in == CMD_WRITE) begin
                                state_d = ADDR;
                                is_rd_d = 1'b0;
                            end else if (byte_in == CMD_READ) begin
                                state_d = ADDR;
                                is_rd_d = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        nib_d   = ~nib_q;
                        shift_d = byte_in;
                        if (nib_q) begin
                            addr_d  = byte_in;
                            state_d = is_rd_q ? DUMMY : WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (sck_rise) begin
                        nib_d   = ~nib_q;
                        shift_d = byte_in;
                        if (nib_q) begin
                            reg_wdata_d = byte_in;
                            reg_addr_d  = addr_q;
                            reg_we_d    = 1'b1;
                            addr_d      = addr_q + 8'd1;
                        end
                    end
                end
                DUMMY: begin
                    if (sck_rise) begin
                        nib_d = ~nib_q;
                        if (nib_q) begin
                            reg_addr_d = addr_q;
                            reg_re_d   = 1'b1;
                            nib_d      = 1'b0;
                            state_d    = RDATA;
                        end
                    end
                end
                RDATA: begin
                    if (sck_rise) begin
                        nib_d = ~nib_q;
                        if (nib_q) begin
                            addr_d     = addr_q + 8'd1;
                            reg_addr_d = addr_q + 8'd1;
                            reg_re_d   = 1'b1;
                        end
                    end
                    if (sck_fall) begin
                        io_out_d = nib_q ? shift_q[NIB_W-1:0] : shift_q[BYTE_W-1:NIB_W];
                        io_oe_d  = 4'hF;
                    end
                end
                IGNORE: begin
                    io_oe_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_target_regs.sv
// tb_qspi_target_regs: directed and randomized host transactions against a byte-array register model.
module tb_qspi_target_regs;

    localparam int SCK_HALF = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       qspi_csb = 1'b1;
    logic       qspi_sck = 1'b0;
    logic [3:0] qspi_io_in = 4'h0;
    logic [3:0] qspi_io_out;
    logic [3:0] qspi_io_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    qspi_target_regs dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .qspi_csb   (qspi_csb),
        .qspi_sck   (qspi_sck),
        .qspi_io_in (qspi_io_in),
        .qspi_io_out(qspi_io_out),
        .qspi_io_oe (qspi_io_oe),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata)
    );

    always #5 clk = ~clk;

    // Register-file slave: registered read data one clk after reg_re
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] rdata_q = 8'h00;
    assign reg_rdata = rdata_q;
    always @(posedge clk) begin
        if (reg_re) rdata_q <= mem[reg_addr];
        if (reg_we) mem[reg_addr] <= reg_wdata;
    end

    // Bus monitor
    logic [7:0] we_a[$];
    logic [7:0] we_d[$];
    logic [7:0] re_a[$];
    int         both_cnt = 0;
    int         oe_bad = 0;
    logic [3:0] oe_or = 4'h0;
    always @(negedge clk) begin
        if (reg_we) begin
            we_a.push_back(reg_addr);
            we_d.push_back(reg_wdata);
        end
        if (reg_re) re_a.push_back(reg_addr);
        if (reg_we && reg_re) both_cnt++;
        if (qspi_io_oe != 4'h0 && qspi_io_oe != 4'hF) oe_bad++;
        oe_or = oe_or | qspi_io_oe;
    end

    int         checks = 0;
    int         errors = 0;
    logic [3:0] last_rx, last_oe, pre_oe;
    logic [7:0] rx[$];
    int         rx_oe_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nib(input logic [3:0] v);
        qspi_io_in = v;
        #(SCK_HALF);
        last_rx = qspi_io_out;
        last_oe = qspi_io_oe;
        qspi_sck = 1'b1;
        #(SCK_HALF);
        qspi_sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        nib(b[7:4]);
        pre_oe = pre_oe | last_oe;
        nib(b[3:0]);
        pre_oe = pre_oe | last_oe;
    endtask

    task automatic dummy2();
        nib(4'h0);
        pre_oe = pre_oe | last_oe;
        nib(4'h0);
        pre_oe = pre_oe | last_oe;
    endtask

    task automatic read_bytes(input int n);
        logic [3:0] hi;
        rx.delete();
        rx_oe_bad = 0;
        for (int i = 0; i < n; i++) begin
            nib(4'h0);
            hi = last_rx;
            if (last_oe !== 4'hF) rx_oe_bad++;
            nib(4'h0);
            if (last_oe !== 4'hF) rx_oe_bad++;
            rx.push_back({hi, last_rx});
        end
    endtask

    task automatic begin_tx();
        #($urandom_range(0, 9));
        qspi_csb = 1'b0;
        #(SCK_HALF);
    endtask

    task automatic end_tx();
        #(SCK_HALF);
        qspi_csb = 1'b1;
        #(4 * SCK_HALF);
    endtask

    task automatic clear_mon();
        we_a.delete();
        we_d.delete();
        re_a.delete();
        oe_or  = 4'h0;
        pre_oe = 4'h0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_io_out"}, 32'(qspi_io_out), 32'h0);
        chk({tag, "_io_oe"}, 32'(qspi_io_oe), 32'h0);
        chk({tag, "_reg_addr"}, 32'(reg_addr), 32'h0);
        chk({tag, "_reg_wdata"}, 32'(reg_wdata), 32'h0);
        chk({tag, "_reg_we"}, 32'(reg_we), 32'h0);
        chk({tag, "_reg_re"}, 32'(reg_re), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        int         mism;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end

        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // SCK activity with CSB high does nothing
        clear_mon();
        repeat (4) nib(4'hA);
        #(4 * SCK_HALF);
        chk("idle_sck_strobes", 32'(we_a.size() + re_a.size()), 32'd0);

        // Write: 0x02, addr 0x10, data A5 3C
        clear_mon();
        begin_tx();
        send_byte(8'h02); send_byte(8'h10); send_byte(8'hA5); send_byte(8'h3C);
        end_tx();
        chk("wr_count", 32'(we_a.size()), 32'd2);
        chk("wr0_addr", 32'(we_a[0]), 32'h10);
        chk("wr0_data", 32'(we_d[0]), 32'hA5);
        chk("wr1_addr", 32'(we_a[1]), 32'h11);
        chk("wr1_data", 32'(we_d[1]), 32'h3C);
        chk("wr_no_re", 32'(re_a.size()), 32'd0);

        // Read with address wrap: FE, FF, 00
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
        clear_mon();
        begin_tx();
        send_byte(8'h0B); send_byte(8'hFE);
        dummy2();
        read_bytes(3);
        end_tx();
        chk("rd_pre_oe", 32'(pre_oe), 32'h0);
        chk("rd_data_oe", 32'(rx_oe_bad), 32'd0);
        chk("rd_byte0", 32'(rx[0]), 32'h11);
        chk("rd_byte1", 32'(rx[1]), 32'h22);
        chk("rd_byte2", 32'(rx[2]), 32'h33);
        chk("rd_re_count", 32'(re_a.size()), 32'd4);
        chk("rd_re0", 32'(re_a[0]), 32'hFE);
        chk("rd_re1", 32'(re_a[1]), 32'hFF);
        chk("rd_re2", 32'(re_a[2]), 32'h00);
        chk("rd_no_we", 32'(we_a.size()), 32'd0);
        chk("rd_oe_after_csb", 32'(qspi_io_oe), 32'h0);

        // Unknown command is ignored
        clear_mon();
        begin_tx();
        send_byte(8'h55);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        end_tx();
        chk("bad_cmd_strobes", 32'(we_a.size() + re_a.size()), 32'd0);
        chk("bad_cmd_oe", 32'(oe_or), 32'h0);

        // Abort after a high nibble, then a clean write
        clear_mon();
        begin_tx();
        send_byte(8'h02); send_byte(8'h40); nib(4'h7);
        end_tx();
        chk("abort_no_we", 32'(we_a.size()), 32'd0);
        begin_tx();
        send_byte(8'h02); send_byte(8'h40); send_byte(8'h77);
        end_tx();
        chk("after_abort_count", 32'(we_a.size()), 32'd1);
        chk("after_abort_addr", 32'(we_a[0]), 32'h40);
        chk("after_abort_data", 32'(we_d[0]), 32'h77);

        // Reset during the data phase of a read
        mem[8'h20] = 8'h9C; mem[8'h30] = 8'hD4; mem[8'h31] = 8'h6B;
        begin_tx();
        send_byte(8'h0B); send_byte(8'h20);
        dummy2();
        read_bytes(1);
        chk("pre_reset_byte", 32'(rx[0]), 32'h9C);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_outputs_zero("midrst");
        clear_mon();
        repeat (6) nib(4'h0);
        end_tx();
        chk("post_reset_strobes", 32'(we_a.size() + re_a.size()), 32'd0);
        chk("post_reset_oe", 32'(oe_or), 32'h0);
        begin_tx();
        send_byte(8'h0B); send_byte(8'h30);
        dummy2();
        read_bytes(2);
        end_tx();
        chk("post_reset_rd0", 32'(rx[0]), 32'hD4);
        chk("post_reset_rd1", 32'(rx[1]), 32'h6B);

        // 256 random bytes read back at f_clk/8 with random SCK phase
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            mem[i]     = ref_mem[i];
        end
        a = 8'($urandom);
        clear_mon();
        begin_tx();
        send_byte(8'h0B); send_byte(a);
        dummy2();
        read_bytes(256);
        end_tx();
        for (int i = 0; i < 256; i++) begin
            chk("rand_byte", 32'(rx[i]), 32'(ref_mem[8'(int'(a) + i)]));
        end
        chk("rand_oe", 32'(rx_oe_bad), 32'd0);
        chk("rand_re_count", 32'(re_a.size()), 32'd257);
        mism = 0;
        for (int i = 0; i < re_a.size(); i++) begin
            if (re_a[i] !== 8'(int'(a) + i)) mism++;
        end
        chk("rand_re_addr", 32'(mism), 32'd0);

        // Global invariants
        chk("we_re_overlap", 32'(both_cnt), 32'd0);
        chk("oe_partial", 32'(oe_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
